branch_predict_unit: RTL and testbench

Parametrised branch prediction and resolution unit for the RV32IM pipeline. The IF stage looks up a direct-mapped branch history table and branch target buffer (BHT/BTB) to predict direction and target. The EX stage evaluates the six RV32 conditional branches with correct signed and unsigned compares. It flags mispredicts, supplies the redirect PC, trains the tables on the following clock edge, and keeps saturating performance counters.

---
 rtl/branch_predict_unit_if.sv | 38 +++
 rtl/branch_predict_unit.sv | 106 ++++++++++
 tb/tb_branch_predict_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolution signals of the branch predict unit.
// The pipeline side uses master; the predictor itself uses slave.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_IF;
  logic            PRED_TAKEN;
  logic [XLEN-1:0] PRED_TARGET;
  logic            EX_VALID;
  logic            EX_IS_BRANCH;
  logic [2:0]      EX_FUNCT3;
  logic [XLEN-1:0] EX_DATA1;
  logic [XLEN-1:0] EX_DATA2;
  logic [XLEN-1:0] EX_PC;
  logic [XLEN-1:0] EX_TARGET;
  logic            EX_PRED_TAKEN;
  logic [XLEN-1:0] EX_PRED_TARGET;
  logic            STALL;
  logic            BRANCH_TAKEN;
  logic            MISPREDICT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic [31:0]     BRANCH_COUNT;
  logic [31:0]     MISPREDICT_COUNT;

  modport master (
    output PC_IF, EX_VALID, EX_IS_BRANCH, EX_FUNCT3, EX_DATA1, EX_DATA2,
           EX_PC, EX_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET, STALL,
    input  PRED_TAKEN, PRED_TARGET, BRANCH_TAKEN, MISPREDICT, REDIRECT_PC,
           BRANCH_COUNT, MISPREDICT_COUNT
  );

  modport slave (
    input  PC_IF, EX_VALID, EX_IS_BRANCH, EX_FUNCT3, EX_DATA1, EX_DATA2,
           EX_PC, EX_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET, STALL,
    output PRED_TAKEN, PRED_TARGET, BRANCH_TAKEN, MISPREDICT, REDIRECT_PC,
           BRANCH_COUNT, MISPREDICT_COUNT
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB lookup at fetch, RV32 branch resolution at execute,
// table training on the following edge and saturating performance counters.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input logic                 CLK,
  input logic                 RESET,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BHT_DEPTH-1:0] valid_q;
  logic [1:0]           ctr_q    [BHT_DEPTH];
  logic [TAG_W-1:0]     tag_q    [BHT_DEPTH];
  logic [XLEN-1:0]      target_q [BHT_DEPTH];
  logic [31:0]          br_cnt_q;
  logic [31:0]          mp_cnt_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, pred_taken;
  logic             res, legal, taken, mispredict, train, count_en;
  logic             unused_pc_bits;

  assign if_idx = bus.PC_IF[IDX_W+1:2];
  assign if_tag = bus.PC_IF[XLEN-1:IDX_W+2];
  assign ex_idx = bus.EX_PC[IDX_W+1:2];
  assign ex_tag = bus.EX_PC[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{bus.PC_IF[1:0], bus.EX_PC[1:0]};

  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign pred_taken = if_hit && ctr_q[if_idx][1];

  assign bus.PRED_TAKEN  = pred_taken;
  assign bus.PRED_TARGET = pred_taken ? target_q[if_idx] : bus.PC_IF + XLEN'(4);

  assign res   = bus.EX_VALID && bus.EX_IS_BRANCH;
  assign legal = (bus.EX_FUNCT3 != 3'b010) && (bus.EX_FUNCT3 != 3'b011);

  always_comb begin
    taken = 1'b0;
    if (res) begin
      case (bus.EX_FUNCT3)
        3'b000:  taken = (bus.EX_DATA1 == bus.EX_DATA2);
        3'b001:  taken = (bus.EX_DATA1 != bus.EX_DATA2);
        3'b100:  taken = ($signed(bus.EX_DATA1) <  $signed(bus.EX_DATA2));
        3'b101:  taken = ($signed(bus.EX_DATA1) >= $signed(bus.EX_DATA2));
        3'b110:  taken = (bus.EX_DATA1 <  bus.EX_DATA2);
        3'b111:  taken = (bus.EX_DATA1 >= bus.EX_DATA2);
        default: taken = 1'b0;
      endcase
    end
  end

  // A correct direction with a stale target still needs a redirect.
  assign mispredict = res && ((taken != bus.EX_PRED_TAKEN) ||
                              (taken && (bus.EX_PRED_TARGET != bus.EX_TARGET)));

  assign bus.BRANCH_TAKEN     = taken;
  assign bus.MISPREDICT       = mispredict;
  assign bus.REDIRECT_PC      = taken ? bus.EX_TARGET : bus.EX_PC + XLEN'(4);
  assign bus.BRANCH_COUNT     = br_cnt_q;
  assign bus.MISPREDICT_COUNT = mp_cnt_q;

  assign count_en = res && !bus.STALL;
  assign train    = count_en && legal;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (train) begin
      if (taken) begin
        if (ex_hit) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
        end else begin
          valid_q[ex_idx] <= 1'b1;
          ctr_q[ex_idx]   <= 2'b10;
        end
      end else if (ex_hit) begin
        if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
      end
    end
  end

  // Tag and target are only meaningful under a valid bit, so they need no reset.
  always_ff @(posedge CLK) begin
    if (train && taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= bus.EX_TARGET;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (count_en) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed checks of branch_predict_unit against an
// array-based predictor model kept in the bench.
module tb_branch_predict_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_fail = 0;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  longint      m_bc, m_mc;
  logic [31:0] pool    [8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic bit m_dir(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic set_ex(input bit v, input bit br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptg, input bit st);
    bus.EX_VALID       = v;
    bus.EX_IS_BRANCH   = br;
    bus.EX_FUNCT3      = f3;
    bus.EX_DATA1       = a;
    bus.EX_DATA2       = b;
    bus.EX_PC          = pc;
    bus.EX_TARGET      = tgt;
    bus.EX_PRED_TAKEN  = ptk;
    bus.EX_PRED_TARGET = ptg;
    bus.STALL          = st;
  endtask

  task automatic idle(input logic [31:0] pc_if);
    bus.PC_IF = pc_if;
    set_ex(1'b0, 1'b0, 3'b000, 0, 0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Branch whose direction is forced via BEQ/BNE on equal operands; prediction
  // carried down the pipe is whatever the model currently predicts.
  task automatic branch(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit st);
    set_ex(1'b1, 1'b1, tk ? 3'b000 : 3'b001, 32'h5, 32'h5, pc, tgt,
           m_pred(pc), m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4, st);
  endtask

  // Check all outputs against the model, advance one clock, update the model.
  task automatic cycle();
    bit res, tk, mp, pt;
    logic [31:0] exp_pt, exp_rd, pc_if;
    int i;
    #1;
    pc_if  = bus.PC_IF;
    pt     = m_pred(pc_if);
    exp_pt = pt ? m_tgt[idx_of(pc_if)] : pc_if + 32'd4;
    chk("pred_taken", 32'(bus.PRED_TAKEN), 32'(pt));
    chk("pred_target", bus.PRED_TARGET, exp_pt);
    res = bus.EX_VALID && bus.EX_IS_BRANCH;
    tk  = res && m_dir(bus.EX_FUNCT3, bus.EX_DATA1, bus.EX_DATA2);
    mp  = res && ((tk != bus.EX_PRED_TAKEN) || (tk && bus.EX_PRED_TARGET != bus.EX_TARGET));
    exp_rd = tk ? bus.EX_TARGET : bus.EX_PC + 32'd4;
    chk("branch_taken", 32'(bus.BRANCH_TAKEN), 32'(tk));
    chk("mispredict", 32'(bus.MISPREDICT), 32'(mp));
    chk("redirect_pc", bus.REDIRECT_PC, exp_rd);
    chk("branch_count", bus.BRANCH_COUNT, 32'(m_bc));
    chk("mispredict_count", bus.MISPREDICT_COUNT, 32'(m_mc));
    @(posedge CLK);
    if (!RESET && res && !bus.STALL) begin
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (bus.EX_FUNCT3 != 3'b010 && bus.EX_FUNCT3 != 3'b011) begin
        i = idx_of(bus.EX_PC);
        if (tk) begin
          if (m_hit(bus.EX_PC)) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(bus.EX_PC);
            m_ctr[i]   = 2;
          end
          m_tgt[i] = bus.EX_TARGET;
        end else if (m_hit(bus.EX_PC)) begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] alias_pc, dpool [6];
    longint bc0;
    alias_pc = 32'h200 + 4 * DEPTH;
    pool[0] = 32'h200;      pool[1] = 32'h204;     pool[2] = alias_pc;
    pool[3] = 32'h1000;     pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h208;
    pool[6] = 32'h600;      pool[7] = 32'h604 + 4 * DEPTH;

    // Reset state
    RESET = 1'b1;
    idle(32'h100);
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_pred_taken", 32'(bus.PRED_TAKEN), 32'h0);
    chk("rst_pred_target", bus.PRED_TARGET, 32'h104);
    chk("rst_branch_count", bus.BRANCH_COUNT, 32'h0);
    chk("rst_mp_count", bus.MISPREDICT_COUNT, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    cycle();

    // Signed vs unsigned compare
    set_ex(1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h340, 1'b0, 32'h0, 1'b0);
    #1;
    chk("blt_taken", 32'(bus.BRANCH_TAKEN), 32'h1);
    chk("blt_mispredict", 32'(bus.MISPREDICT), 32'h1);
    chk("blt_redirect", bus.REDIRECT_PC, 32'h340);
    cycle();
    set_ex(1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h304, 32'h340, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bltu_taken", 32'(bus.BRANCH_TAKEN), 32'h0);
    chk("bltu_mispredict", 32'(bus.MISPREDICT), 32'h0);
    chk("bltu_redirect", bus.REDIRECT_PC, 32'h308);
    cycle();

    // Training sequence at 0x200
    bus.PC_IF = 32'h200;
    branch(32'h200, 32'h180, 1'b1, 1'b0);
    #1;
    chk("same_cycle_no_bypass", 32'(bus.PRED_TAKEN), 32'h0);
    cycle();
    idle(32'h200);
    #1;
    chk("train_wt_taken", 32'(bus.PRED_TAKEN), 32'h1);
    chk("train_wt_target", bus.PRED_TARGET, 32'h180);
    cycle();
    repeat (2) begin branch(32'h200, 32'h180, 1'b0, 1'b0); cycle(); end
    idle(32'h200);
    #1;
    chk("train_snt", 32'(bus.PRED_TAKEN), 32'h0);
    cycle();
    repeat (3) begin branch(32'h200, 32'h180, 1'b1, 1'b0); cycle(); end
    branch(32'h200, 32'h180, 1'b0, 1'b0);
    cycle();
    idle(32'h200);
    #1;
    chk("st_survives_one_nt", 32'(bus.PRED_TAKEN), 32'h1);
    cycle();

    // Aliasing
    branch(alias_pc, 32'h7C0, 1'b1, 1'b0);
    cycle();
    idle(32'h200);
    #1;
    chk("alias_old_miss", 32'(bus.PRED_TAKEN), 32'h0);
    cycle();
    idle(alias_pc);
    #1;
    chk("alias_new_hit", 32'(bus.PRED_TAKEN), 32'h1);
    chk("alias_new_target", bus.PRED_TARGET, 32'h7C0);
    cycle();

    // Stall held 3 cycles, then released
    bc0 = m_bc;
    repeat (3) begin branch(alias_pc, 32'h7C0, 1'b1, 1'b1); cycle(); end
    branch(alias_pc, 32'h7C0, 1'b1, 1'b0);
    cycle();
    idle(alias_pc);
    #1;
    chk("stall_count_once", bus.BRANCH_COUNT, 32'(bc0 + 1));
    cycle();

    // Counter saturation via backdoor preload
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    force dut.mp_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.mp_cnt_q;
    m_bc = 64'hFFFF_FFFE;
    m_mc = 64'hFFFF_FFFE;
    repeat (3) begin
      set_ex(1'b1, 1'b1, 3'b000, 32'h7, 32'h7, 32'h900, 32'h940, 1'b0, 32'h0, 1'b0);
      cycle();
    end
    chk("sat_branch_count", bus.BRANCH_COUNT, 32'hFFFF_FFFF);
    chk("sat_mp_count", bus.MISPREDICT_COUNT, 32'hFFFF_FFFF);

    // Randomized traffic
    dpool[0] = 32'h0; dpool[1] = 32'h1; dpool[2] = 32'hFFFF_FFFF;
    dpool[3] = 32'h8000_0000; dpool[4] = 32'h7FFF_FFFF;
    for (int n = 0; n < 500; n++) begin
      logic [31:0] pc, a, b;
      bit usep;
      pc = pool[$urandom_range(0, 7)];
      dpool[5] = $urandom;
      a = dpool[$urandom_range(0, 5)];
      b = ($urandom_range(0, 3) == 0) ? a : dpool[$urandom_range(0, 5)];
      usep = ($urandom_range(0, 3) != 0);
      bus.PC_IF = pool[$urandom_range(0, 7)];
      set_ex(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
             3'($urandom_range(0, 7)), a, b, pc, {$urandom_range(0, 255), 2'b00},
             usep ? m_pred(pc) : 1'($urandom),
             (usep && m_pred(pc)) ? m_tgt[idx_of(pc)] : {$urandom_range(0, 255), 2'b00},
             ($urandom_range(0, 3) == 0));
      cycle();
    end

    // Reset asserted mid-training
    idle(alias_pc);
    branch(alias_pc, 32'h7C0, 1'b1, 1'b0);
    bus.PC_IF = alias_pc;
    if (!m_pred(alias_pc)) begin
      cycle();
      branch(alias_pc, 32'h7C0, 1'b1, 1'b0);
      bus.PC_IF = alias_pc;
    end
    #1;
    chk("pre_reset_hit", 32'(bus.PRED_TAKEN), 32'h1);
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("midrst_pred_taken", 32'(bus.PRED_TAKEN), 32'h0);
    chk("midrst_pred_target", bus.PRED_TARGET, alias_pc + 32'd4);
    chk("midrst_branch_count", bus.BRANCH_COUNT, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    idle(alias_pc);
    cycle();
    chk("post_reset_count", bus.BRANCH_COUNT, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
